// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - modulo-N up/down counter built from per-bit JK excitation stages
module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cmd,
    input  logic             dir,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] j_exc,
    output logic [WIDTH-1:0] k_exc,
    output logic             tc,
    output logic             wrap
);

    // Command encoding mirrors the {J,K} inputs of a single JK stage.
    localparam logic [1:0] CMD_HOLD  = 2'b00;
    localparam logic [1:0] CMD_CLEAR = 2'b01;
    localparam logic [1:0] CMD_LOAD  = 2'b10;
    localparam logic [1:0] CMD_COUNT = 2'b11;

    // Highest legal count, and the modulus one bit wider so 2^WIDTH fits.
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_V = (WIDTH + 1)'(MODULUS);

    generate
        if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
            $error("jk_mod_counter: WIDTH must be in 2..16");
        end
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("jk_mod_counter: MODULUS must be in 2..2^WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;

    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] load_sat;
    logic             at_max;
    logic             at_zero;
    logic             out_of_range;

    // State decode; out_of_range can only be true after an upset when MODULUS < 2^WIDTH.
    always_comb begin
        at_max       = (q_q == MAX_V);
        at_zero      = (q_q == '0);
        out_of_range = ({1'b0, q_q} >= MOD_V);
        load_sat     = (load_val > MAX_V) ? MAX_V : load_val;
    end

    // Target value for the next edge; illegal states recover toward the count direction.
    always_comb begin
        next_q = q_q;
        case (cmd)
            CMD_HOLD:  next_q = q_q;
            CMD_CLEAR: next_q = '0;
            CMD_LOAD:  next_q = load_sat;
            CMD_COUNT: begin
                if (dir) begin
                    next_q = (at_max || out_of_range) ? '0 : q_q + WIDTH'(1);
                end else begin
                    next_q = (at_zero || out_of_range) ? MAX_V : q_q - WIDTH'(1);
                end
            end
            default:   next_q = q_q;
        endcase
    end

    // JK excitation from current/target bits, then the JK characteristic equation per bit.
    always_comb begin
        j_exc = ~q_q & next_q;
        k_exc = q_q & ~next_q;
        q_d   = (j_exc & ~q_q) | (~k_exc & q_q);
    end

    // Terminal count looks at direction and state only; wrap is a counted pass through tc.
    always_comb begin
        tc     = (dir & at_max) | (~dir & at_zero);
        wrap_d = (cmd == CMD_COUNT) & tc;
    end

    // Register the count and the wrap pulse; reset clears both, dropping any pending wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q     = q_q;
    assign q_bar = ~q_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb/tb_jk_mod_counter.sv - self-checking bench for jk_mod_counter against an arithmetic model
module tb_jk_mod_counter;

    logic       clk;
    logic       rst;
    logic [1:0] cmd;
    logic       dir;
    logic [3:0] lv_a;
    logic [1:0] lv_b;

    logic [3:0] a_q, a_qb, a_j, a_k;
    logic       a_tc, a_wrap;
    logic [1:0] b_q, b_qb, b_j, b_k;
    logic       b_tc, b_wrap;

    int n_chk  = 0;
    int n_fail = 0;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
        .clk(clk), .rst(rst), .cmd(cmd), .dir(dir), .load_val(lv_a),
        .q(a_q), .q_bar(a_qb), .j_exc(a_j), .k_exc(a_k), .tc(a_tc), .wrap(a_wrap)
    );

    jk_mod_counter #(.WIDTH(2), .MODULUS(2)) dut_b (
        .clk(clk), .rst(rst), .cmd(cmd), .dir(dir), .load_val(lv_b),
        .q(b_q), .q_bar(b_qb), .j_exc(b_j), .k_exc(b_k), .tc(b_tc), .wrap(b_wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain modular arithmetic on integers.
    function automatic int m_next(int qv, int c, int d, int lv, int m);
        case (c)
            0:       return qv;
            1:       return 0;
            2:       return (lv > m - 1) ? m - 1 : lv;
            default: return d ? (qv + 1) % m : (qv + m - 1) % m;
        endcase
    endfunction

    function automatic int m_tc(int qv, int d, int m);
        return d ? int'(qv == m - 1) : int'(qv == 0);
    endfunction

    int  ma_q, mb_q, ma_w, mb_w;
    bit  m_valid = 0;

    // Model advances on every rising edge with the inputs the DUT samples.
    always @(posedge clk) begin
        if (rst) begin
            ma_q = 0; mb_q = 0; ma_w = 0; mb_w = 0;
            m_valid = 1;
        end else if (m_valid) begin
            ma_w = (cmd == 2'b11) ? m_tc(ma_q, int'(dir), 10) : 0;
            mb_w = (cmd == 2'b11) ? m_tc(mb_q, int'(dir), 2) : 0;
            ma_q = m_next(ma_q, int'(cmd), int'(dir), int'(lv_a), 10);
            mb_q = m_next(mb_q, int'(cmd), int'(dir), int'(lv_b), 2);
        end
    end

    logic [3:0] pa_q, pa_j, pa_k;
    logic [1:0] pb_q, pb_j, pb_k;
    bit         have_prev = 0;
    logic       p_rst;

    // Per-cycle compare against the model, plus the JK characteristic equation across each edge.
    always @(negedge clk) begin
        if (m_valid) begin
            int na, nb;
            na = m_next(ma_q, int'(cmd), int'(dir), int'(lv_a), 10);
            nb = m_next(mb_q, int'(cmd), int'(dir), int'(lv_b), 2);
            chk("a_q",    a_q,    ma_q);
            chk("a_qbar", a_qb,   ma_q ^ 15);
            chk("a_tc",   a_tc,   m_tc(ma_q, int'(dir), 10));
            chk("a_wrap", a_wrap, ma_w);
            chk("a_j",    a_j,    ~ma_q & na & 15);
            chk("a_k",    a_k,    ma_q & ~na & 15);
            chk("a_jk0",  a_j & a_k, 0);
            chk("b_q",    b_q,    mb_q);
            chk("b_qbar", b_qb,   mb_q ^ 3);
            chk("b_tc",   b_tc,   m_tc(mb_q, int'(dir), 2));
            chk("b_wrap", b_wrap, mb_w);
            chk("b_j",    b_j,    ~mb_q & nb & 3);
            chk("b_k",    b_k,    mb_q & ~nb & 3);
            if (have_prev && !p_rst) begin
                chk("a_char", a_q, (pa_j & ~pa_q) | (~pa_k & pa_q));
                chk("b_char", b_q, (pb_j & ~pb_q) | (~pb_k & pb_q));
            end
            pa_q = a_q; pa_j = a_j; pa_k = a_k;
            pb_q = b_q; pb_j = b_j; pb_k = b_k;
            p_rst = rst;
            have_prev = 1;
        end
    end

    task automatic step(input logic r, input logic [1:0] c, input logic d, input logic [3:0] lv);
        rst  = r;
        cmd  = c;
        dir  = d;
        lv_a = lv;
        @(posedge clk);
        #1;
    endtask

    int up_exp[12]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int dn_dir[6]    = '{0, 0, 0, 0, 1, 1};
    int dn_exp[6]    = '{1, 0, 9, 8, 9, 0};
    int dn_wrap[6]   = '{0, 0, 1, 0, 0, 1};

    initial begin
        rst = 1'b1; cmd = 2'b11; dir = 1'b0; lv_a = 4'd0; lv_b = 2'd0;

        // Reset with count command pending
        step(1, 2'b11, 0, 0);
        step(1, 2'b11, 0, 0);
        chk("rst_q",    a_q, 0);
        chk("rst_qbar", a_qb, 4'hF);
        chk("rst_wrap", a_wrap, 0);
        chk("rst_tc_dn", a_tc, 1);
        chk("rst_b_qbar", b_qb, 2'h3);
        dir = 1'b1;
        #1;
        chk("rst_tc_up", a_tc, 0);

        // Count up through the wrap; dut_b toggles 1,0 with wrap on every 0
        for (int i = 0; i < 12; i++) begin
            step(0, 2'b11, 1, 0);
            chk("up_q",    a_q, up_exp[i]);
            chk("up_wrap", a_wrap, (i == 9) ? 1 : 0);
            chk("up_tc",   a_tc, (up_exp[i] == 9) ? 1 : 0);
            chk("b_up_q",    b_q, (i + 1) % 2);
            chk("b_up_wrap", b_wrap, ((i + 1) % 2 == 0) ? 1 : 0);
        end

        // Down through zero, then direction change up through nine
        for (int i = 0; i < 6; i++) begin
            step(0, 2'b11, dn_dir[i][0], 0);
            chk("dn_q",    a_q, dn_exp[i]);
            chk("dn_wrap", a_wrap, dn_wrap[i]);
        end

        // Load, saturating load, clear, hold
        step(0, 2'b10, 1, 4'd7);
        chk("ld7_q", a_q, 7);
        chk("ld7_wrap", a_wrap, 0);
        step(0, 2'b10, 1, 4'd13);
        chk("ld13_q", a_q, 9);
        step(0, 2'b10, 1, 4'd9);
        chk("ld9_q", a_q, 9);
        step(0, 2'b01, 1, 4'd0);
        chk("clr_q", a_q, 0);
        chk("clr_wrap", a_wrap, 0);
        step(0, 2'b10, 0, 4'd5);
        for (int i = 0; i < 3; i++) begin
            step(0, 2'b00, i[0], 4'd2);
            chk("hold_q", a_q, 5);
        end

        // Excitation at 0111 counting up
        step(0, 2'b10, 1, 4'd7);
        cmd = 2'b11; dir = 1'b1;
        #1;
        chk("exc_j", a_j, 4'b1000);
        chk("exc_k", a_k, 4'b0111);
        step(0, 2'b11, 1, 4'd0);
        chk("exc_q", a_q, 4'b1000);

        // Reset mid-count at q=5
        step(0, 2'b10, 1, 4'd5);
        step(1, 2'b11, 1, 4'd0);
        chk("rmid_q", a_q, 0);
        chk("rmid_wrap", a_wrap, 0);
        step(0, 2'b11, 1, 4'd0);
        chk("rmid_next", a_q, 1);

        // Randomised run checked by the model every cycle
        for (int i = 0; i < 200; i++) begin
            lv_b = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 31) == 0), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
